// File: rtl/l2cache_control_if.sv
// L1 request and physical-memory handshake bundle for the L2 controller.
// master = controller side, slave = L1/pmem side.
interface l2cache_control_if;
  logic mem_read;
  logic mem_write;
  logic mem_resp;
  logic pmem_read;
  logic pmem_write;
  logic pmem_resp;

  modport master (
    input  mem_read, mem_write, pmem_resp,
    output mem_resp, pmem_read, pmem_write
  );
  modport slave (
    output mem_read, mem_write, pmem_resp,
    input  mem_resp, pmem_read, pmem_write
  );
endinterface

// File: rtl/l2cache_control.sv
// Control FSM for a 4-way, 8-set, write-back/write-allocate L2 datapath.
// Optional performance counters are built only when L2_PERF_CNT_EN is defined.
module l2cache_control #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  l2cache_control_if.master    bus,
  input  logic                 hit_signal,
  input  logic                 dirty_out,
  output logic                 data_write,
  output logic                 tag_update,
  output logic                 LRU_write,
  output logic                 dirty_update,
  output logic                 dirty_bit_mux_sel,
  output logic                 data_write_mux_sel,
  output logic                 select_sig_mux_sel,
  output logic                 pmem_address_mux_sel,
  input  logic                 perf_clear,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count,
  output logic [CNT_WIDTH-1:0] wb_count
);

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;

  state_t state, next;
  logic   refill, refill_next;
  logic   req;
  logic   hit_ev, miss_ev, wb_ev;

  assign req = bus.mem_read | bus.mem_write;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      refill <= 1'b0;
    end else begin
      state  <= next;
      refill <= refill_next;
    end
  end

  always_comb begin
    next                 = state;
    refill_next          = refill;
    bus.mem_resp         = 1'b0;
    bus.pmem_read        = 1'b0;
    bus.pmem_write       = 1'b0;
    data_write           = 1'b0;
    tag_update           = 1'b0;
    LRU_write            = 1'b0;
    dirty_update         = 1'b0;
    dirty_bit_mux_sel    = 1'b0;
    data_write_mux_sel   = 1'b0;
    select_sig_mux_sel   = 1'b0;
    pmem_address_mux_sel = 1'b0;
    hit_ev               = 1'b0;
    miss_ev              = 1'b0;
    wb_ev                = 1'b0;
    case (state)
      IDLE: begin
        refill_next = 1'b0;
        if (req) next = COMPARE;
      end
      COMPARE: begin
        // a request abandoned during a miss leaves the filled line behind silently
        if (!req) begin
          next = IDLE;
        end else if (hit_signal) begin
          bus.mem_resp       = 1'b1;
          select_sig_mux_sel = 1'b1;
          LRU_write          = 1'b1;
          hit_ev             = ~refill;
          next               = IDLE;
          if (bus.mem_write) begin
            data_write         = 1'b1;
            data_write_mux_sel = 1'b1;
            dirty_update       = 1'b1;
            dirty_bit_mux_sel  = 1'b1;
          end
        end else begin
          miss_ev = 1'b1;
          next    = dirty_out ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        bus.pmem_write       = 1'b1;
        pmem_address_mux_sel = 1'b1;
        if (bus.pmem_resp) begin
          wb_ev = 1'b1;
          next  = ALLOCATE;
        end
      end
      ALLOCATE: begin
        bus.pmem_read = 1'b1;
        if (bus.pmem_resp) begin
          data_write   = 1'b1;
          tag_update   = 1'b1;
          dirty_update = 1'b1;
          refill_next  = 1'b1;
          next         = COMPARE;
        end
      end
      default: next = IDLE;
    endcase
  end

`ifdef L2_PERF_CNT_EN
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else if (perf_clear) begin
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      if (hit_ev  && hit_count  != CNT_MAX) hit_count  <= hit_count  + CNT_WIDTH'(1);
      if (miss_ev && miss_count != CNT_MAX) miss_count <= miss_count + CNT_WIDTH'(1);
      if (wb_ev   && wb_count   != CNT_MAX) wb_count   <= wb_count   + CNT_WIDTH'(1);
    end
  end
`else
  logic unused_perf;
  assign unused_perf = ^{perf_clear, hit_ev, miss_ev, wb_ev};
  assign hit_count   = '0;
  assign miss_count  = '0;
  assign wb_count    = '0;
`endif

endmodule

// File: tb/tb_l2cache_control.sv
// Bench for l2cache_control: a cache/pmem model plays the datapath and memory and
// predicts every cycle's strobes and counter values from the transaction rules.
module tb_l2cache_control;
`ifdef L2_PERF_CNT_EN
  localparam int CW   = 2;
  localparam bit PERF = 1'b1;
`else
  localparam int CW   = 16;
  localparam bit PERF = 1'b0;
`endif
  localparam int CMAX = (1 << CW) - 1;

  // output vector: {mem_resp, pmem_read, pmem_write, data_write, tag_update, LRU_write,
  //                 dirty_update, dirty_bit_sel, data_write_sel, select_sel, pmem_addr_sel}
  localparam logic [10:0] V_ZERO   = 11'b00000000000;
  localparam logic [10:0] V_HIT_RD = 11'b10000100010;
  localparam logic [10:0] V_HIT_WR = 11'b10010111110;
  localparam logic [10:0] V_WB     = 11'b00100000001;
  localparam logic [10:0] V_AL     = 11'b01000000000;
  localparam logic [10:0] V_FILL   = 11'b01011010000;

  logic clk = 1'b0;
  logic reset_n;
  logic hit_signal, dirty_out, perf_clear;
  logic data_write, tag_update, LRU_write, dirty_update;
  logic dirty_bit_mux_sel, data_write_mux_sel, select_sig_mux_sel, pmem_address_mux_sel;
  logic [CW-1:0] hit_count, miss_count, wb_count;

  always #5 clk = ~clk;

  l2cache_control_if bus();

  l2cache_control #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .hit_signal(hit_signal), .dirty_out(dirty_out),
    .data_write(data_write), .tag_update(tag_update), .LRU_write(LRU_write),
    .dirty_update(dirty_update), .dirty_bit_mux_sel(dirty_bit_mux_sel),
    .data_write_mux_sel(data_write_mux_sel), .select_sig_mux_sel(select_sig_mux_sel),
    .pmem_address_mux_sel(pmem_address_mux_sel), .perf_clear(perf_clear),
    .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
  );

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  int m_hit = 0, m_miss = 0, m_wb = 0;
  int clr_mode = 0;
  bit chk_on = 1'b0;
  logic [10:0] exp_out = V_ZERO;

  // cache contents as the datapath would hold them
  bit vld[8][4];
  int tg[8][4];
  bit drt[8][4];
  int stamp[8][4];
  int tick = 0;

  task automatic check(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("outputs", {bus.mem_resp, bus.pmem_read, bus.pmem_write, data_write, tag_update,
                        LRU_write, dirty_update, dirty_bit_mux_sel, data_write_mux_sel,
                        select_sig_mux_sel, pmem_address_mux_sel}, 64'(exp_out));
      check("pmem_rd_wr_exclusive", 64'(bus.pmem_read & bus.pmem_write), 64'(0));
      check("hit_count",  64'(hit_count),  64'(PERF ? m_hit  : 0));
      check("miss_count", 64'(miss_count), 64'(PERF ? m_miss : 0));
      check("wb_count",   64'(wb_count),   64'(PERF ? m_wb   : 0));
    end
  end

  function automatic int lookup(input int s, input int t);
    for (int w = 0; w < 4; w++) if (vld[s][w] && tg[s][w] == t) return w;
    return -1;
  endfunction

  function automatic int victim(input int s);
    int v = 0;
    for (int w = 0; w < 4; w++) if (!vld[s][w]) return w;
    for (int w = 1; w < 4; w++) if (stamp[s][w] < stamp[s][v]) v = w;
    return v;
  endfunction

  // One clock: drive inputs, state expectations, then account for the edge.
  task automatic cycle(input logic rd, input logic wr, input logic hs, input logic dout,
                       input logic presp, input logic [10:0] ex,
                       input bit hi, input bit mi, input bit wb);
    logic pclr;
    pclr = (clr_mode == 2) ? 1'b1 : (clr_mode == 1) ? ($urandom_range(0, 15) == 0) : 1'b0;
    bus.mem_read = rd; bus.mem_write = wr; bus.pmem_resp = presp;
    hit_signal = hs; dirty_out = dout; perf_clear = pclr; exp_out = ex;
    @(posedge clk);
    if (!reset_n || pclr) begin
      m_hit = 0; m_miss = 0; m_wb = 0;
    end else begin
      if (hi && m_hit  < CMAX) m_hit++;
      if (mi && m_miss < CMAX) m_miss++;
      if (wb && m_wb   < CMAX) m_wb++;
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 1'($urandom_range(0, 1)), V_ZERO, 0, 0, 0);
  endtask

  task automatic do_req(input int addr, input bit wr, input bit both, input int L, input int W,
                        input bit drop, output int lat);
    int s, t, way, v, t0;
    logic rd, wl, dv;
    logic [10:0] vh;
    s  = (addr >> 4) & 7;
    t  = addr >> 7;
    rd = !wr || both;
    wl = wr;
    vh = wr ? V_HIT_WR : V_HIT_RD;
    t0 = cyc;
    way = lookup(s, t);
    cycle(rd, wl, 0, 0, 1'($urandom_range(0, 1)), V_ZERO, 0, 0, 0);
    if (way >= 0) begin
      cycle(rd, wl, 1, drt[s][way], 1'($urandom_range(0, 1)), vh, 1, 0, 0);
      stamp[s][way] = ++tick;
      if (wr) drt[s][way] = 1'b1;
    end else begin
      v  = victim(s);
      dv = vld[s][v] && drt[s][v];
      cycle(rd, wl, 0, dv, 1'($urandom_range(0, 1)), V_ZERO, 0, 1, 0);
      if (dv)
        for (int i = 0; i < W; i++) cycle(rd, wl, 0, 1, i == W - 1, V_WB, 0, 0, i == W - 1);
      for (int i = 0; i < L; i++)
        cycle(drop ? 1'b0 : rd, drop ? 1'b0 : wl, 0, 0, i == L - 1,
              (i == L - 1) ? V_FILL : V_AL, 0, 0, 0);
      vld[s][v] = 1'b1; tg[s][v] = t; drt[s][v] = 1'b0;
      cycle(drop ? 1'b0 : rd, drop ? 1'b0 : wl, 1, 0, 1'($urandom_range(0, 1)),
            drop ? V_ZERO : vh, 0, 0, 0);
      if (!drop) begin
        stamp[s][v] = ++tick;
        if (wr) drt[s][v] = 1'b1;
      end
    end
    lat = cyc - t0;
  endtask

  initial begin
    int lat;
    reset_n = 1'b0;
    bus.mem_read = 0; bus.mem_write = 0; bus.pmem_resp = 0;
    hit_signal = 0; dirty_out = 0; perf_clear = 0;
    chk_on = 1'b1;
    cycle(0, 0, 1, 1, 1, V_ZERO, 0, 0, 0);
    cycle(1, 1, 1, 1, 1, V_ZERO, 0, 0, 0);
    reset_n = 1'b1;
    idle(1);

    // cold read: IDLE, COMPARE miss, 5 ALLOCATE cycles, COMPARE hit
    do_req(16'h1230, 0, 0, 5, 1, 0, lat);
    check("cold_read_latency", 64'(lat), 64'(8));
`ifdef L2_PERF_CNT_EN
    check("cold_miss_count", 64'(miss_count), 64'(1));
    check("cold_hit_count", 64'(hit_count), 64'(0));
`endif
    do_req(16'h1230, 0, 0, 5, 1, 0, lat);
    check("read_hit_latency", 64'(lat), 64'(2));
    do_req(16'h1230, 1, 0, 5, 1, 0, lat);
    check("write_hit_latency", 64'(lat), 64'(2));

    // fill set 3; 0x0630 evicts dirty 0x1230, 0x0830 evicts dirty 0x0030
    do_req(16'h0030, 1, 0, 2, 1, 0, lat);
    do_req(16'h0230, 0, 0, 3, 1, 0, lat);
    do_req(16'h0430, 0, 0, 1, 1, 0, lat);
    do_req(16'h0630, 0, 0, 2, 2, 0, lat);
    do_req(16'h0830, 0, 0, 4, 3, 0, lat);
`ifdef L2_PERF_CNT_EN
    check("wb_count_after_evictions", 64'(wb_count), 64'(2));
`endif

    // reset while ALLOCATE holds pmem_read
    cycle(1, 0, 0, 0, 0, V_ZERO, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, V_ZERO, 0, 1, 0);
    cycle(1, 0, 0, 0, 0, V_AL, 0, 0, 0);
    check("alloc_pmem_read", 64'(bus.pmem_read), 64'(1));
    reset_n = 1'b0;
    m_hit = 0; m_miss = 0; m_wb = 0;
    exp_out = V_ZERO;
    #1;
    check("reset_drops_pmem_read", 64'(bus.pmem_read), 64'(0));
    cycle(1, 0, 1, 1, 1, V_ZERO, 0, 0, 0);
    reset_n = 1'b1;
    idle(1);
    do_req(16'h1270, 0, 0, 3, 1, 0, lat);
    check("post_reset_miss_latency", 64'(lat), 64'(6));

    // read+write together, then a request abandoned mid-fill
    do_req(16'h0150, 1, 1, 2, 1, 0, lat);
    do_req(16'h0150, 1, 1, 2, 1, 0, lat);
    do_req(16'h0360, 0, 0, 3, 1, 1, lat);
    idle(1);
    do_req(16'h0360, 0, 0, 3, 1, 0, lat);
    check("fill_survives_drop", 64'(lat), 64'(2));

    // saturation and clear-over-increment
    for (int i = 0; i < 5; i++) do_req(16'h0830, 0, 0, 1, 1, 0, lat);
`ifdef L2_PERF_CNT_EN
    check("hit_count_saturates", 64'(hit_count), 64'(3));
`endif
    clr_mode = 2;
    do_req(16'h0830, 0, 0, 1, 1, 0, lat);
    clr_mode = 0;
`ifdef L2_PERF_CNT_EN
    check("clear_beats_hit", 64'(hit_count), 64'(0));
`endif

    // random traffic
    clr_mode = 1;
    for (int n = 0; n < 300; n++) begin
      do_req(($urandom_range(0, 7) << 7) | ($urandom_range(0, 7) << 4),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom_range(1, 6), $urandom_range(1, 4), $urandom_range(0, 19) == 0, lat);
      idle($urandom_range(0, 2));
    end
    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
